// File: rtl/datapath_trace_buffer_pkg.sv
// Shared definitions for the datapath trace buffer: capture-state encoding,
// default parameter values and the packing layout of one trace entry.
// Entry layout (LSB first): pc | rs2 | alu | cycle stamp.
package datapath_trace_buffer_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CYC_W_DEF = 32;
  localparam int unsigned PC_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned OFF_PC = 0;

  function automatic int unsigned off_rs2(input int unsigned xlen);
    return xlen;
  endfunction

  function automatic int unsigned off_alu(input int unsigned xlen);
    return 2 * xlen;
  endfunction

  function automatic int unsigned off_cyc(input int unsigned xlen);
    return 3 * xlen;
  endfunction

  function automatic int unsigned entry_w(input int unsigned xlen, input int unsigned cyc_w);
    return 3 * xlen + cyc_w;
  endfunction

endpackage

// File: rtl/datapath_trace_buffer_if.sv
// Sample and readout bus of the trace buffer.
//   master: drives sample_* and rd_en, receives rd_valid/rd_*
//   slave : the trace buffer side
interface datapath_trace_buffer_if
  import datapath_trace_buffer_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
);

  logic             sample_valid;
  logic [XLEN-1:0]  sample_pc;
  logic [XLEN-1:0]  sample_rs2;
  logic [XLEN-1:0]  sample_alu;
  logic             rd_en;
  logic             rd_valid;
  logic [XLEN-1:0]  rd_pc;
  logic [XLEN-1:0]  rd_rs2;
  logic [XLEN-1:0]  rd_alu;
  logic [CYC_W-1:0] rd_cycle;

  modport master (
    output sample_valid, sample_pc, sample_rs2, sample_alu, rd_en,
    input  rd_valid, rd_pc, rd_rs2, rd_alu, rd_cycle
  );

  modport slave (
    input  sample_valid, sample_pc, sample_rs2, sample_alu, rd_en,
    output rd_valid, rd_pc, rd_rs2, rd_alu, rd_cycle
  );

endinterface

// File: rtl/datapath_trace_buffer_ram.sv
// Trace storage: DEPTH x WIDTH array, one write port, one registered read port.
// Ports: clock, reset (clears only the read register), we/waddr/wdata,
//        re/raddr, rdata (valid the cycle after re).
module datapath_trace_buffer_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 224,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset so it maps onto a plain RAM macro.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read register, holds its value between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/datapath_trace_buffer.sv
// Execution-trace capture unit. Records {pc, rs2, alu, cycle stamp} per
// eligible sample into a circular buffer, stops on breakpoint + post-trigger
// count (or on fill when the breakpoint is disabled), then holds the trace for
// in-order readout with one cycle of read latency.
// Ports: clock, reset (async, active high), arm, clear, bus (sample/readout
//        interface, slave side), bp_enable, bp_addr, post_count,
//        state, triggered, overflow, count.
// Optional: DATAPATH_TRACE_FILTER_EN adds filt_lo/filt_hi; only samples with
//           filt_lo <= pc <= filt_hi (unsigned) are eligible.
module datapath_trace_buffer
  import datapath_trace_buffer_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned CYC_W = CYC_W_DEF,
  parameter  int unsigned PC_W  = PC_W_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    clear,
  datapath_trace_buffer_if.slave  bus,
  input  logic                    bp_enable,
  input  logic [XLEN-1:0]         bp_addr,
  input  logic [PC_W-1:0]         post_count,
`ifdef DATAPATH_TRACE_FILTER_EN
  input  logic [XLEN-1:0]         filt_lo,
  input  logic [XLEN-1:0]         filt_hi,
`endif
  output logic [1:0]              state,
  output logic                    triggered,
  output logic                    overflow,
  output logic [CNT_W-1:0]        count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_w(XLEN, CYC_W);
  localparam int unsigned OFF_RS2 = off_rs2(XLEN);
  localparam int unsigned OFF_ALU = off_alu(XLEN);
  localparam int unsigned OFF_CYC = off_cyc(XLEN);

  state_t            st_q, st_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [PC_W-1:0]   rem_q, rem_d;
  logic              trig_q, trig_d;
  logic              ovf_q, ovf_d;
  logic              rv_q, rv_d;
  logic              we, re;
  logic              eligible;
  logic              full;
  logic              bp_hit;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;

  // Sample eligibility: out-of-range samples look exactly like idle cycles.
`ifdef DATAPATH_TRACE_FILTER_EN
  assign eligible = bus.sample_valid && (bus.sample_pc >= filt_lo) && (bus.sample_pc <= filt_hi);
`else
  assign eligible = bus.sample_valid;
`endif

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign bp_hit  = eligible && bp_enable && (bus.sample_pc == bp_addr);
  assign wr_data = {cyc_q, bus.sample_alu, bus.sample_rs2, bus.sample_pc};

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      rem_q    <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      rem_q    <= rem_d;
      trig_q   <= trig_d;
      ovf_q    <= ovf_d;
      rv_q     <= rv_d;
    end
  end

  // Next-state and control: clear beats arm, arm beats read/sample.
  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    rem_d    = rem_q;
    trig_d   = trig_q;
    ovf_d    = ovf_q;
    rv_d     = 1'b0;
    we       = 1'b0;
    re       = 1'b0;

    if (clear) begin
      st_d   = ST_IDLE;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      trig_d = 1'b0;
    end else if (arm && (st_q == ST_IDLE || st_q == ST_DONE)) begin
      st_d     = ST_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      cyc_d    = '0;
      rem_d    = '0;
      trig_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (st_q)
        ST_ARMED, ST_POST: begin
          cyc_d = cyc_q + CYC_W'(1);
          if (eligible) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            // A full buffer drops its oldest entry to make room.
            if (full) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              ovf_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (st_q == ST_ARMED) begin
              if (bp_enable) begin
                if (bp_hit) begin
                  trig_d = 1'b1;
                  if (post_count == '0) begin
                    st_d = ST_DONE;
                  end else begin
                    st_d  = ST_POST;
                    rem_d = post_count;
                  end
                end
              end else if (full || cnt_q == CNT_W'(DEPTH - 1)) begin
                st_d = ST_DONE;
              end
            end else begin
              rem_d = rem_q - PC_W'(1);
              if (rem_q == PC_W'(1)) begin
                st_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (bus.rd_en && cnt_q != '0) begin
            re       = 1'b1;
            rv_d     = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  datapath_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign state        = st_q;
  assign triggered    = trig_q;
  assign overflow     = ovf_q;
  assign count        = cnt_q;
  assign bus.rd_valid = rv_q;
  assign bus.rd_pc    = rd_data[OFF_PC +: XLEN];
  assign bus.rd_rs2   = rd_data[OFF_RS2 +: XLEN];
  assign bus.rd_alu   = rd_data[OFF_ALU +: XLEN];
  assign bus.rd_cycle = rd_data[OFF_CYC +: CYC_W];

endmodule

// File: tb/tb_datapath_trace_buffer.sv
// Scoreboard bench for datapath_trace_buffer (DEPTH=4): directed scenarios
// followed by randomized capture/readout, checked against a queue-based
// reference model of the trace behaviour.
module tb_datapath_trace_buffer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CYC_W = 32;
  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_POST  = 2;
  localparam int S_DONE  = 3;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] rs2;
    logic [63:0] alu;
    logic [31:0] cyc;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              arm;
  logic              clear;
  logic              bp_enable;
  logic [XLEN-1:0]   bp_addr;
  logic [PC_W-1:0]   post_count;
  logic [1:0]        state;
  logic              triggered;
  logic              overflow;
  logic [CNT_W-1:0]  count;
`ifdef DATAPATH_TRACE_FILTER_EN
  logic [XLEN-1:0]   filt_lo;
  logic [XLEN-1:0]   filt_hi;
`endif

  datapath_trace_buffer_if #(.XLEN(XLEN), .CYC_W(CYC_W)) bus ();

  datapath_trace_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CYC_W (CYC_W),
    .PC_W  (PC_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .clear      (clear),
    .bus        (bus),
    .bp_enable  (bp_enable),
    .bp_addr    (bp_addr),
    .post_count (post_count),
`ifdef DATAPATH_TRACE_FILTER_EN
    .filt_lo    (filt_lo),
    .filt_hi    (filt_hi),
`endif
    .state      (state),
    .triggered  (triggered),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model
  int          m_state;
  bit          m_trig;
  bit          m_ovf;
  bit          m_rv;
  int unsigned m_cyc;
  int          m_rem;
  ent_t        m_buf[$];
  ent_t        exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic bit in_range(input logic [63:0] pc);
`ifdef DATAPATH_TRACE_FILTER_EN
    return (pc >= filt_lo) && (pc <= filt_hi);
`else
    return pc === pc;
`endif
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_trig  = 0;
    m_ovf   = 0;
    m_rv    = 0;
    m_cyc   = 0;
    m_rem   = 0;
    m_buf.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input bit a, input bit c, input bit sv, input ent_t e, input bit rde);
    m_rv = 0;
    if (c) begin
      m_state = S_IDLE;
      m_buf.delete();
      m_trig = 0;
      m_ovf  = 0;
    end else if (a && (m_state == S_IDLE || m_state == S_DONE)) begin
      m_state = S_ARMED;
      m_buf.delete();
      m_cyc  = 0;
      m_trig = 0;
      m_ovf  = 0;
    end else if (m_state == S_ARMED || m_state == S_POST) begin
      e.cyc = m_cyc;
      m_cyc = m_cyc + 1;
      if (sv && in_range(e.pc)) begin
        m_buf.push_back(e);
        if (m_buf.size() > int'(DEPTH)) begin
          void'(m_buf.pop_front());
          m_ovf = 1;
        end
        if (m_state == S_ARMED) begin
          if (bp_enable) begin
            if (e.pc == bp_addr) begin
              m_trig = 1;
              if (post_count == 0) m_state = S_DONE;
              else begin
                m_state = S_POST;
                m_rem   = int'(post_count);
              end
            end
          end else if (m_buf.size() == int'(DEPTH)) begin
            m_state = S_DONE;
          end
        end else begin
          m_rem--;
          if (m_rem == 0) m_state = S_DONE;
        end
      end
    end else if (m_state == S_DONE && rde && m_buf.size() > 0) begin
      exp_q.push_back(m_buf.pop_front());
      m_rv = 1;
    end
  endtask

  // One clock of stimulus, then per-cycle status comparison against the model.
  task automatic tick(input bit a, input bit c, input bit sv, input logic [63:0] pc, input bit rde);
    ent_t e;
    @(negedge clock);
    e.pc  = pc;
    e.rs2 = {$urandom, $urandom};
    e.alu = {$urandom, $urandom};
    e.cyc = '0;
    arm              = a;
    clear            = c;
    bus.sample_valid = sv;
    bus.sample_pc    = pc;
    bus.sample_rs2   = e.rs2;
    bus.sample_alu   = e.alu;
    bus.rd_en        = rde;
    model_step(a, c, sv, e, rde);
    @(posedge clock);
    #1;
    check("state", 64'(state), 64'(m_state));
    check("count", 64'(count), 64'(m_buf.size()));
    check("triggered", 64'(triggered), 64'(m_trig));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("rd_valid", 64'(bus.rd_valid), 64'(m_rv));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 64'h0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2; i++) tick(0, 0, 0, 64'h0, 1);
  endtask

  // Monitor: every rd_valid pulse is matched against the oldest expected entry.
  initial begin
    ent_t me;
    forever begin
      @(posedge clock);
      #1;
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected: actual rd_valid=1 required no pending read");
        end else begin
          me = exp_q.pop_front();
          check("rd_pc", bus.rd_pc, me.pc);
          check("rd_rs2", bus.rd_rs2, me.rs2);
          check("rd_alu", bus.rd_alu, me.alu);
          check("rd_cycle", 64'(bus.rd_cycle), 64'(me.cyc));
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    arm              = 1'b0;
    clear            = 1'b0;
    bp_enable        = 1'b0;
    bp_addr          = '0;
    post_count       = '0;
    bus.sample_valid = 1'b0;
    bus.sample_pc    = '0;
    bus.sample_rs2   = '0;
    bus.sample_alu   = '0;
    bus.rd_en        = 1'b0;
`ifdef DATAPATH_TRACE_FILTER_EN
    filt_lo = '0;
    filt_hi = '1;
`endif
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("reset_state", 64'(state), 64'(0));
    check("reset_count", 64'(count), 64'(0));
    check("reset_triggered", 64'(triggered), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    check("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("reset_rd_pc", bus.rd_pc, 64'(0));
    check("reset_rd_cycle", 64'(bus.rd_cycle), 64'(0));
    reset = 1'b0;

    // Fill mode: stops exactly when the buffer becomes full.
    bp_enable = 1'b0;
    tick(1, 0, 0, 64'h0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 64'(4 * i), 0);
    check("fill_done_state", 64'(state), 64'(S_DONE));
    check("fill_count", 64'(count), 64'(4));
    check("fill_overflow", 64'(overflow), 64'(0));
    drain();

    // Breakpoint at 16 with one post-trigger sample; oldest entries overwritten.
    bp_enable  = 1'b1;
    bp_addr    = 64'd16;
    post_count = 8'd1;
    tick(1, 0, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 64'(4 * i), 0);
    check("bp_triggered", 64'(triggered), 64'(1));
    check("bp_overflow", 64'(overflow), 64'(1));
    check("bp_count", 64'(count), 64'(4));
    drain();

    // Trigger on the very first sample with no post samples.
    bp_addr    = 64'd0;
    post_count = 8'd0;
    tick(1, 0, 0, 64'h0, 0);
    tick(0, 0, 1, 64'h0, 0);
    check("bp0_state", 64'(state), 64'(S_DONE));
    check("bp0_count", 64'(count), 64'(1));
    drain();

    // Gaps in sample_valid keep their cycle-stamp gaps; then clear+arm in DONE.
    bp_enable = 1'b0;
    tick(1, 0, 0, 64'h0, 0);
    tick(0, 0, 1, 64'h0, 0);
    tick(0, 0, 0, 64'hdead, 0);
    tick(0, 0, 1, 64'h8, 0);
    check("gap_count", 64'(count), 64'(2));
    tick(0, 0, 1, 64'hc, 0);
    tick(0, 0, 1, 64'h10, 0);
    drain();
    tick(1, 1, 0, 64'h0, 1);
    check("clear_arm_state", 64'(state), 64'(S_IDLE));
    check("clear_arm_count", 64'(count), 64'(0));

    // Asynchronous reset in the middle of POST takes effect before the next edge.
    bp_enable  = 1'b1;
    bp_addr    = 64'd4;
    post_count = 8'd3;
    tick(1, 0, 0, 64'h0, 0);
    tick(0, 0, 1, 64'h0, 0);
    tick(0, 0, 1, 64'h4, 0);
    tick(0, 0, 1, 64'h8, 0);
    check("pre_reset_state", 64'(state), 64'(S_POST));
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_state", 64'(state), 64'(0));
    check("async_count", 64'(count), 64'(0));
    check("async_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("async_triggered", 64'(triggered), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Randomized captures, clears, re-arms and readouts.
    for (int r = 0; r < 30; r++) begin
      bp_enable  = 1'($urandom_range(0, 1));
      bp_addr    = 64'(4 * $urandom_range(0, 15));
      post_count = 8'($urandom_range(0, 5));
      tick(1, 0, 0, 64'h0, 0);
      for (int k = 0; k < 40; k++) begin
        tick(($urandom % 30) == 0, ($urandom % 60) == 0, ($urandom % 4) != 0,
             64'(4 * $urandom_range(0, 15)),
             (m_state == S_DONE) && (($urandom % 2) == 0));
      end
      drain();
    end

    idle(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/datapath_trace_buffer.md
Name: datapath_trace_buffer

Overview:
Synthesizable execution-trace capture unit for the RISC-V datapath. It is the on-chip successor to per-cycle PC/operand/ALU printouts.
- Records {PC, rs2 value, ALU result, cycle stamp} per retired sample into a circular buffer.
- Stops on a PC breakpoint plus a programmable post-trigger count, or on buffer full.
- Holds the frozen trace for in-order readout.

Parameters:
XLEN, 64, datapath word width of PC/rs2/ALU fields
DEPTH, 16, entries in trace buffer (power of two, >=2)
CYC_W, 32, cycle-stamp width
PC_W, 8, post_count width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
arm  in  1  start capture (IDLE or DONE)
clear  in  1  abort/flush to IDLE
sample_valid  in  1  sample fields valid this cycle
sample_pc  in  XLEN  PC of sampled instruction
sample_rs2  in  XLEN  rs2 read data
sample_alu  in  XLEN  ALU output
bp_enable  in  1  breakpoint trigger enabled
bp_addr  in  XLEN  breakpoint PC
post_count  in  PC_W  samples captured after trigger
rd_en  in  1  pop oldest entry (DONE only)
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
triggered  out  1  breakpoint matched this capture
overflow  out  1  sticky: oldest entry overwritten
count  out  $clog2(DEPTH+1)  valid entries held
rd_valid  out  1  rd_* valid this cycle
rd_pc, rd_rs2, rd_alu  out  XLEN  popped entry fields
rd_cycle  out  CYC_W  popped entry cycle stamp

Behaviour:
- Reset (async, any state): state=IDLE; triggered=0, overflow=0, count=0, rd_valid=0; rd_* data=0; pointers, cycle counter and remaining counter =0.
- Priority, same cycle: reset > clear > arm > rd_en/sample.
- clear, any state: next cycle IDLE, count=0, overflow=0, triggered=0.
- IDLE: samples ignored. arm -> ARMED; pointers, count and cycle counter zeroed.
- Cycle counter: equals 0 in the first ARMED cycle. Increments every clock in ARMED/POST, wraps modulo 2^CYC_W. Frozen in IDLE/DONE.
- Write rule (ARMED/POST, sample_valid=1): entry written at wr_ptr with current cycle counter; wr_ptr wraps at DEPTH.
  - count<DEPTH: count++.
  - count==DEPTH: rd_ptr advances (oldest dropped), overflow<=1.
- ARMED, bp_enable=1: sample_valid && sample_pc==bp_addr -> sample written, triggered<=1.
  - post_count==0 -> DONE.
  - otherwise -> POST with remaining=post_count.
- ARMED, bp_enable=0: DONE when the write makes count==DEPTH. No overwrite occurs in this mode.
- POST: each valid sample written, remaining--. Write that brings remaining to 0 -> DONE. Triggering sample is not counted in post_count.
- DONE: samples ignored.
  - rd_en && count>0: next cycle rd_valid=1 with oldest entry; rd_ptr++, count--.
  - rd_en && count==0: rd_valid=0.
  - rd_valid is a single-cycle pulse per accepted rd_en; back-to-back rd_en gives one entry per cycle.
  - arm -> ARMED, buffer flushed.
- rd_en outside DONE is ignored.
- Read latency 1 cycle (synchronous RAM read).

Optional Feature:
DATAPATH_TRACE_FILTER_EN
- Defined: adds inputs filt_lo, filt_hi (XLEN). Only samples with filt_lo<=sample_pc<=filt_hi (unsigned) are recorded, counted toward post_count/fill, or compared for breakpoint. Out-of-range samples behave as sample_valid=0.
- Undefined: ports absent; every valid sample is eligible.

Decomposition:
- Package trace_pkg: state encoding constants (IDLE/ARMED/POST/DONE), entry width ENTRY_W = 3*XLEN+CYC_W, and field offsets for pack/unpack.
- Sub-module trace_ram: DEPTH x ENTRY_W storage, one write port, one synchronous read port, no reset on storage array.
- Control FSM, pointers and counters live in datapath_trace_buffer.

Test Plan:
- DEPTH=4, bp_enable=0, arm, then PCs 0,4,8,12 on consecutive cycles -> DONE after 4th write, count=4, overflow=0. Four rd_en give PCs 0,4,8,12 with rd_cycle 0,1,2,3.
- bp_addr=16, post_count=1, PCs 0,4,...,28 every cycle -> trigger at 16, capture 20, then DONE. Buffer reads 8,12,16,20; overflow=1, triggered=1; PCs 24,28 absent.
- bp_addr=0, post_count=0, first sample PC=0 -> DONE next cycle, count=1. Readout PC 0 with rd_alu/rd_rs2 matching driven values.
- sample_valid toggling 1,0,1 with PCs 0,X,8 in fill mode -> only 0 and 8 stored. Stamps 0 and 2 (gaps preserved).
- In DONE with count=0: rd_en -> rd_valid stays 0. In DONE: clear and arm same cycle -> IDLE next cycle, count=0.
- Assert reset mid-POST between clock edges -> state=IDLE, count=0, rd_valid=0, triggered=0 immediately, before the next edge.
